gb_noiseregisters: RTL and testbench

//  CPU-facing register block for Channel 4 (noise), NR41-NR44. Decodes bus reads/writes and

---
 rtl/gb_noiseregisters.sv | 172 +++++++++++++++++
 tb/tb_gb_noiseregisters.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_noiseregisters.sv
// Noise channel (NR41-NR44) register block: bus decode, field outputs, trigger pulse, masked readback.
// Fields and read data update one cycle after the strobe edge; no backpressure, every strobe is accepted.
module gb_noiseregisters #(
    parameter logic [7:0] BASE_ADDR   = 8'h20,
    parameter int         START_WIDTH = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       apu_enable,
    input  logic [7:0] addr,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       ch_enable,
    output logic [5:0] length,
    output logic [3:0] initial_volume,
    output logic       envelope_increasing,
    output logic [2:0] num_envelope_sweeps,
    output logic [3:0] shift_clock_freq,
    output logic       counter_width,
    output logic [2:0] freq_dividing_ratio,
    output logic       single,
    output logic       start,
    output logic       dac_enable,
    output logic       ch_active
);

    localparam logic [7:0] A41 = BASE_ADDR;
    localparam logic [7:0] A42 = BASE_ADDR + 8'd1;
    localparam logic [7:0] A43 = BASE_ADDR + 8'd2;
    localparam logic [7:0] A44 = BASE_ADDR + 8'd3;
    localparam int         CW  = (START_WIDTH > 1) ? $clog2(START_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(START_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_GAP} state_t;

    state_t        state, state_nx;
    logic          pending, pending_nx;
    logic [CW-1:0] cnt, cnt_nx;

    logic [5:0] nr41;
    logic [7:0] nr42;
    logic [7:0] nr43;
    logic       nr44_single;

    logic wr41, wr42, wr43, wr44;
    logic dac_now, dac_post, dac_kill, trig_req;
    logic [7:0] q42, q43;
    logic       q44;
    logic [7:0] rd_mux;

    assign wr41 = apu_enable & wr_en & (addr == A41);
    assign wr42 = apu_enable & wr_en & (addr == A42);
    assign wr43 = apu_enable & wr_en & (addr == A43);
    assign wr44 = apu_enable & wr_en & (addr == A44);

    assign dac_now  = (nr42[7:3] != 5'd0);
    assign dac_post = wr42 ? (wr_data[7:3] != 5'd0) : dac_now;
    assign dac_kill = wr42 & (wr_data[7:3] == 5'd0);
    assign trig_req = wr44 & wr_data[7] & dac_post;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nr41        <= 6'd0;
            nr42        <= 8'd0;
            nr43        <= 8'd0;
            nr44_single <= 1'b0;
        end else if (!apu_enable) begin
            nr41        <= 6'd0;
            nr42        <= 8'd0;
            nr43        <= 8'd0;
            nr44_single <= 1'b0;
        end else begin
            if (wr41) nr41 <= wr_data[5:0];
            if (wr42) nr42 <= wr_data;
            if (wr43) nr43 <= wr_data;
            if (wr44) nr44_single <= wr_data[6];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            pending <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= state_nx;
            pending <= pending_nx;
            cnt     <= cnt_nx;
        end
    end

    // A request arriving while GAP is already leaving with a pending trigger merges into it.
    always_comb begin
        state_nx   = state;
        pending_nx = pending;
        cnt_nx     = cnt;
        if (!apu_enable || dac_kill) begin
            state_nx   = S_IDLE;
            pending_nx = 1'b0;
            cnt_nx     = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (trig_req) begin
                        state_nx = S_HIGH;
                        cnt_nx   = '0;
                    end
                end
                S_HIGH: begin
                    if (trig_req) pending_nx = 1'b1;
                    if (cnt == LAST) state_nx = S_GAP;
                    else             cnt_nx   = cnt + CW'(1);
                end
                S_GAP: begin
                    if (pending || trig_req) begin
                        state_nx   = S_HIGH;
                        cnt_nx     = '0;
                        pending_nx = 1'b0;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
                default: begin
                    state_nx   = S_IDLE;
                    pending_nx = 1'b0;
                    cnt_nx     = '0;
                end
            endcase
        end
    end

    // While powered down the stored values are masked so reads see the cleared state at once.
    assign q42 = apu_enable ? nr42 : 8'h00;
    assign q43 = apu_enable ? nr43 : 8'h00;
    assign q44 = apu_enable & nr44_single;

    always_comb begin
        rd_mux = 8'hFF;
        case (addr)
            A42:     rd_mux = q42;
            A43:     rd_mux = q43;
            A44:     rd_mux = {1'b1, q44, 6'h3F};
            default: rd_mux = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
        end else begin
            rd_data  <= rd_en ? rd_mux : 8'h00;
            rd_valid <= rd_en;
        end
    end

    assign length              = nr41;
    assign initial_volume      = nr42[7:4];
    assign envelope_increasing = nr42[3];
    assign num_envelope_sweeps = nr42[2:0];
    assign shift_clock_freq    = nr43[7:4];
    assign counter_width       = nr43[3];
    assign freq_dividing_ratio = nr43[2:0];
    assign single              = nr44_single;
    assign start               = (state == S_HIGH);
    assign dac_enable          = dac_now;
    assign ch_active           = ch_enable & dac_now;

endmodule

// File: tb/tb_gb_noiseregisters.sv
// Bench for gb_noiseregisters: register table with read scoreboard, plus trigger-pulse and reset sequences.
module tb_gb_noiseregisters;

    logic       clk = 1'b0;
    logic       reset;
    logic       apu_enable;
    logic [7:0] addr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       ch_enable;
    logic [5:0] length;
    logic [3:0] initial_volume;
    logic       envelope_increasing;
    logic [2:0] num_envelope_sweeps;
    logic [3:0] shift_clock_freq;
    logic       counter_width;
    logic [2:0] freq_dividing_ratio;
    logic       single;
    logic       start;
    logic       dac_enable;
    logic       ch_active;

    always #5 clk = ~clk;

    gb_noiseregisters #(.BASE_ADDR(8'h20), .START_WIDTH(1)) dut (
        .clk                 (clk),
        .reset               (reset),
        .apu_enable          (apu_enable),
        .addr                (addr),
        .wr_en               (wr_en),
        .wr_data             (wr_data),
        .rd_en               (rd_en),
        .rd_data             (rd_data),
        .rd_valid            (rd_valid),
        .ch_enable           (ch_enable),
        .length              (length),
        .initial_volume      (initial_volume),
        .envelope_increasing (envelope_increasing),
        .num_envelope_sweeps (num_envelope_sweeps),
        .shift_clock_freq    (shift_clock_freq),
        .counter_width       (counter_width),
        .freq_dividing_ratio (freq_dividing_ratio),
        .single              (single),
        .start               (start),
        .dac_enable          (dac_enable),
        .ch_active           (ch_active)
    );

    typedef struct {
        logic       apu;
        logic       wr;
        logic [7:0] waddr;
        logic [7:0] wdat;
        logic       rd;
        logic [7:0] raddr;
        logic [7:0] rexp;
        logic [5:0] len;
        logic [7:0] nr42;
        logic [7:0] nr43;
    } vec_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] sb_q[$];
    logic [7:0] sb_exp;
    vec_t       tbl[18];
    logic [7:0] pat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && rd_valid) begin
            if (sb_q.size() == 0) begin
                check("rd_valid_unexpected", 32'd1, 32'd0);
            end else begin
                sb_exp = sb_q.pop_front();
                check("rd_data", {24'd0, rd_data}, {24'd0, sb_exp});
            end
        end
    end

    function automatic vec_t mk(input logic apu, input logic wr, input logic [7:0] wa, input logic [7:0] wd,
                                input logic rd, input logic [7:0] ra, input logic [7:0] re,
                                input logic [5:0] len, input logic [7:0] e42, input logic [7:0] e43);
        vec_t v;
        v.apu = apu; v.wr = wr; v.waddr = wa; v.wdat = wd;
        v.rd = rd; v.raddr = ra; v.rexp = re;
        v.len = len; v.nr42 = e42; v.nr43 = e43;
        return v;
    endfunction

    task automatic drive(input logic apu, input logic w, input logic [7:0] wa, input logic [7:0] wd,
                         input logic r, input logic [7:0] ra, input logic [7:0] re);
        apu_enable = apu;
        wr_en      = w;
        wr_data    = wd;
        rd_en      = r;
        // a single address bus: reads at a different address use the read address
        addr       = r ? ra : wa;
        if (r) sb_q.push_back(re);
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
        drive(1'b1, 1'b1, a, d, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        idle();
    endtask

    task automatic read_reg(input logic [7:0] a, input logic [7:0] e);
        drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, a, e);
        @(negedge clk);
        idle();
    endtask

    task automatic run_start(input int nw, input logic [7:0] d, output logic [7:0] p);
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            wr_en   = (i < nw);
            addr    = 8'h23;
            wr_data = d;
            @(negedge clk);
            p[7-i] = start;
        end
        wr_en = 1'b0;
    endtask

    initial begin
        reset = 1'b0; apu_enable = 1'b0; addr = 8'h00; wr_en = 1'b0;
        wr_data = 8'h00; rd_en = 1'b0; ch_enable = 1'b0;

        // address 0x20..0x23 = NR41..NR44, 0x24 unmapped; same-address pairs share the bus
        tbl[0]  = mk(1, 1, 8'h20, 8'hC5, 0, 8'h00, 8'h00, 6'h05, 8'h00, 8'h00);
        tbl[1]  = mk(1, 1, 8'h21, 8'hF3, 0, 8'h00, 8'h00, 6'h05, 8'hF3, 8'h00);
        tbl[2]  = mk(1, 1, 8'h22, 8'h5A, 0, 8'h00, 8'h00, 6'h05, 8'hF3, 8'h5A);
        tbl[3]  = mk(1, 0, 8'h00, 8'h00, 1, 8'h21, 8'hF3, 6'h05, 8'hF3, 8'h5A);
        tbl[4]  = mk(1, 0, 8'h00, 8'h00, 1, 8'h22, 8'h5A, 6'h05, 8'hF3, 8'h5A);
        tbl[5]  = mk(1, 0, 8'h00, 8'h00, 1, 8'h20, 8'hFF, 6'h05, 8'hF3, 8'h5A);
        tbl[6]  = mk(1, 0, 8'h00, 8'h00, 1, 8'h24, 8'hFF, 6'h05, 8'hF3, 8'h5A);
        tbl[7]  = mk(1, 1, 8'h22, 8'h11, 1, 8'h22, 8'h5A, 6'h05, 8'hF3, 8'h11);
        tbl[8]  = mk(1, 0, 8'h00, 8'h00, 1, 8'h22, 8'h11, 6'h05, 8'hF3, 8'h11);
        tbl[9]  = mk(1, 1, 8'h21, 8'hF0, 0, 8'h00, 8'h00, 6'h05, 8'hF0, 8'h11);
        tbl[10] = mk(1, 0, 8'h00, 8'h00, 1, 8'h21, 8'hF0, 6'h05, 8'hF0, 8'h11);
        tbl[11] = mk(1, 0, 8'h00, 8'h00, 1, 8'h23, 8'hBF, 6'h05, 8'hF0, 8'h11);
        tbl[12] = mk(0, 1, 8'h22, 8'hFF, 0, 8'h00, 8'h00, 6'h00, 8'h00, 8'h00);
        tbl[13] = mk(0, 0, 8'h00, 8'h00, 1, 8'h22, 8'h00, 6'h00, 8'h00, 8'h00);
        tbl[14] = mk(0, 0, 8'h00, 8'h00, 1, 8'h20, 8'hFF, 6'h00, 8'h00, 8'h00);
        tbl[15] = mk(0, 0, 8'h00, 8'h00, 1, 8'h24, 8'hFF, 6'h00, 8'h00, 8'h00);
        tbl[16] = mk(0, 0, 8'h00, 8'h00, 1, 8'h23, 8'hBF, 6'h00, 8'h00, 8'h00);
        tbl[17] = mk(1, 1, 8'h22, 8'hFF, 1, 8'h22, 8'h00, 6'h00, 8'h00, 8'hFF);

        @(negedge clk);
        check("rst_start", {31'd0, start}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_rd_data", {24'd0, rd_data}, 32'd0);
        check("rst_length", {26'd0, length}, 32'd0);
        check("rst_nr42", {24'd0, initial_volume, envelope_increasing, num_envelope_sweeps}, 32'd0);
        check("rst_nr43", {24'd0, shift_clock_freq, counter_width, freq_dividing_ratio}, 32'd0);
        check("rst_single", {31'd0, single}, 32'd0);
        check("rst_dac", {31'd0, dac_enable}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 18; k++) begin
            drive(tbl[k].apu, tbl[k].wr, tbl[k].waddr, tbl[k].wdat, tbl[k].rd, tbl[k].raddr, tbl[k].rexp);
            @(negedge clk);
            check($sformatf("v%0d_length", k), {26'd0, length}, {26'd0, tbl[k].len});
            check($sformatf("v%0d_nr42", k),
                  {24'd0, initial_volume, envelope_increasing, num_envelope_sweeps}, {24'd0, tbl[k].nr42});
            check($sformatf("v%0d_nr43", k),
                  {24'd0, shift_clock_freq, counter_width, freq_dividing_ratio}, {24'd0, tbl[k].nr43});
        end
        idle();
        apu_enable = 1'b1;
        @(negedge clk);

        ch_enable = 1'b1;
        write_reg(8'h21, 8'hF0);
        check("dac_on", {31'd0, dac_enable}, 32'd1);
        check("ch_active_on", {31'd0, ch_active}, 32'd1);

        run_start(1, 8'hC0, pat);
        check("start_single", {24'd0, pat}, {24'd0, 8'b1000_0000});
        check("single_set", {31'd0, single}, 32'd1);
        read_reg(8'h23, 8'hFF);

        run_start(2, 8'h80, pat);
        check("start_two_writes", {24'd0, pat}, {24'd0, 8'b1010_0000});
        run_start(3, 8'h80, pat);
        check("start_three_writes", {24'd0, pat}, {24'd0, 8'b1010_0000});

        // two requests queue a second pulse; a DAC-off NR42 write in the gap must cancel it
        pat = 8'h00;
        wr_en = 1'b1; addr = 8'h23; wr_data = 8'h80;
        @(negedge clk); pat[7] = start;
        @(negedge clk); pat[6] = start;
        addr = 8'h21; wr_data = 8'h00;
        @(negedge clk); pat[5] = start;
        wr_en = 1'b0;
        @(negedge clk); pat[4] = start;
        check("start_dac_kill", {24'd0, pat}, {24'd0, 8'b1000_0000});
        check("dac_off_after_kill", {31'd0, dac_enable}, 32'd0);

        write_reg(8'h21, 8'h07);
        run_start(1, 8'h80, pat);
        check("start_dac_off", {24'd0, pat}, 32'd0);
        check("dac_off", {31'd0, dac_enable}, 32'd0);
        check("ch_active_dac_off", {31'd0, ch_active}, 32'd0);

        write_reg(8'h21, 8'hF0);
        wr_en = 1'b1; addr = 8'h23; wr_data = 8'h80;
        @(negedge clk);
        check("start_before_reset", {31'd0, start}, 32'd1);
        wr_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("start_async_reset", {31'd0, start}, 32'd0);
        check("nr42_async_reset", {24'd0, initial_volume, envelope_increasing, num_envelope_sweeps}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("start_after_release", {31'd0, start}, 32'd0);
        check("length_after_release", {26'd0, length}, 32'd0);
        check("nr43_after_release", {24'd0, shift_clock_freq, counter_width, freq_dividing_ratio}, 32'd0);
        read_reg(8'h21, 8'h00);

        repeat (3) @(negedge clk);
        check("reads_all_returned", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
